// File: rtl/dbus_responder_pkg.sv
// Shared types and helpers for the data-bus responder and its requesters.
package dbus_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [WORD_W-1:0] data;
  } dbus_req_t;

  // Request legality: alignment for the access size plus a strobe pattern
  // that is either a load (all zero) or exactly the lanes the access covers.
  function automatic logic dbus_strobe_legal(input msize_t size,
                                             input logic [1:0] addr_lo,
                                             input logic [STRB_W-1:0] strobe);
    logic ok;
    ok = 1'b0;
    case (size)
      MSIZE4:  ok = (addr_lo == 2'b00) &&
                    ((strobe == 4'b0000) || (strobe == 4'b1111));
      MSIZE2:  ok = !addr_lo[0] &&
                    ((strobe == 4'b0000) ||
                     (strobe == (addr_lo[1] ? 4'b1100 : 4'b0011)));
      MSIZE1:  ok = (strobe == 4'b0000) || (strobe == (4'b0001 << addr_lo));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Request/response data bus between the memory stage and the data responder.
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  logic                dreq_valid;
  logic [WORD_W-1:0]   dreq_addr;
  msize_t              dreq_size;
  logic [STRB_W-1:0]   dreq_strobe;
  logic [WORD_W-1:0]   dreq_data;
  logic                dresp_addr_ok;
  logic                dresp_data_ok;
  logic [WORD_W-1:0]   dresp_data;
  logic                dresp_err;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );

endinterface

// File: rtl/dbus_word_ram.sv
// Single-port word array with byte-lane writes; the read port shows the
// word as it will be after this cycle's write (write-first).
module dbus_word_ram
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [STRB_W-1:0]     be,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  // Merge the enabled store lanes over the stored word.
  always_comb begin
    rdata_c = mem[idx];
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (be[b]) rdata_c[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Commit enabled lanes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-side memory responder: one request at a time, fixed-latency response
// carrying the full aligned word after any store has been merged.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  dbus_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  dbus_state_t        state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WORD_W-1:0]  data_q, data_next;
  logic               err_q, err_next;
  logic               data_ok_q, data_ok_next;
  logic               accept_c;
  logic               legal_c;
  logic [STRB_W-1:0]  be_c;
  logic [WORD_W-1:0]  rdata_c;
  dbus_req_t          req_c;
  logic               unused_addr_c;

  assign req_c = '{addr:   bus.dreq_addr,
                   size:   bus.dreq_size,
                   strobe: bus.dreq_strobe,
                   data:   bus.dreq_data};

  assign legal_c       = dbus_strobe_legal(req_c.size, req_c.addr[1:0], req_c.strobe);
  assign be_c          = legal_c ? req_c.strobe : '0;
  assign unused_addr_c = ^{req_c.addr[WORD_W-1:DEPTH_LOG2+2], req_c.addr[1:0]};

  dbus_word_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we      (accept_c),
    .idx     (req_c.addr[DEPTH_LOG2+1:2]),
    .be      (be_c),
    .wdata   (req_c.data),
    .rdata_c (rdata_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, accept decision and next values of the response registers.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    data_next  = data_q;
    err_next   = err_q;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dreq_valid && !reset) begin
          accept_c   = 1'b1;
          cnt_next   = LAT_M1;
          data_next  = legal_c ? rdata_c : '0;
          err_next   = !legal_c;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    data_ok_next = (state_next == RESP);
  end

  // Latency counter and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      data_q    <= data_next;
      err_q     <= err_next;
      data_ok_q <= data_ok_next;
    end
  end

  assign bus.dresp_addr_ok = accept_c;
  assign bus.dresp_data_ok = data_ok_q;
  assign bus.dresp_data    = data_q;
  assign bus.dresp_err     = err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: three instances (default, shallow array,
// single-cycle latency) share one request driver selected by sel.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  msize_t      req_size;
  logic [3:0]  req_strobe;

  dbus_responder_if bus0();
  dbus_responder_if bus1();
  dbus_responder_if bus2();

  assign bus0.dreq_valid  = req_valid && (sel == 0);
  assign bus0.dreq_addr   = req_addr;
  assign bus0.dreq_size   = req_size;
  assign bus0.dreq_strobe = req_strobe;
  assign bus0.dreq_data   = req_data;
  assign bus1.dreq_valid  = req_valid && (sel == 1);
  assign bus1.dreq_addr   = req_addr;
  assign bus1.dreq_size   = req_size;
  assign bus1.dreq_strobe = req_strobe;
  assign bus1.dreq_data   = req_data;
  assign bus2.dreq_valid  = req_valid && (sel == 2);
  assign bus2.dreq_addr   = req_addr;
  assign bus2.dreq_size   = req_size;
  assign bus2.dreq_strobe = req_strobe;
  assign bus2.dreq_data   = req_data;

  dbus_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dut_main (.clk(clk), .reset(reset), .bus(bus0));
  dbus_responder #(.DEPTH_LOG2(4),  .LATENCY(2)) dut_wrap (.clk(clk), .reset(reset), .bus(bus1));
  dbus_responder #(.DEPTH_LOG2(12), .LATENCY(1)) dut_lat1 (.clk(clk), .reset(reset), .bus(bus2));

  logic        o_addr_ok, o_data_ok, o_err;
  logic [31:0] o_data;

  always_comb begin
    o_addr_ok = bus0.dresp_addr_ok;
    o_data_ok = bus0.dresp_data_ok;
    o_data    = bus0.dresp_data;
    o_err     = bus0.dresp_err;
    if (sel == 1) begin
      o_addr_ok = bus1.dresp_addr_ok;
      o_data_ok = bus1.dresp_data_ok;
      o_data    = bus1.dresp_data;
      o_err     = bus1.dresp_err;
    end else if (sel == 2) begin
      o_addr_ok = bus2.dresp_addr_ok;
      o_data_ok = bus2.dresp_data_ok;
      o_data    = bus2.dresp_data;
      o_err     = bus2.dresp_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int last_t0 = 0;

  // One request; b2b asserts it should be accepted right after the previous response.
  task automatic xact(input int lat, input msize_t sz, input logic [31:0] a,
                      input logic [3:0] st, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee, input bit b2b,
                      input string tag);
    int t0;
    bit got;
    @(negedge clk);
    if (b2b) chk({tag, " pulse_end"}, o_data_ok, 32'd0);
    req_size = sz; req_addr = a; req_strobe = st; req_data = d; req_valid = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_addr_ok) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk({tag, " accept"}, 32'(got), 32'd1);
    t0 = cyc;
    if (b2b) chk({tag, " b2b_gap"}, 32'(t0 - last_t0), 32'(lat + 1));
    last_t0 = t0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_data_ok) begin got = 1'b1; break; end
    end
    chk({tag, " data_ok"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(cyc - t0), 32'(lat));
    chk({tag, " data"}, o_data, ed);
    chk({tag, " err"}, 32'(o_err), 32'(ee));
  endtask

  initial begin
    int na, nd;
    bit got;
    reset = 1'b1; req_valid = 1'b0; sel = 0;
    req_addr = '0; req_data = '0; req_size = MSIZE4; req_strobe = '0;
    @(negedge clk); @(negedge clk);
    chk("rst addr_ok", 32'(o_addr_ok), 32'd0);
    chk("rst data_ok", 32'(o_data_ok), 32'd0);
    chk("rst data", o_data, 32'd0);
    chk("rst err", 32'(o_err), 32'd0);
    reset = 1'b0;

    // Basic store/load and back-to-back throughput at LATENCY=2.
    xact(2, MSIZE4, 32'h100, 4'b1111, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, "sw100");
    xact(2, MSIZE4, 32'h100, 4'b0000, 32'h0,         32'h1234_5678, 1'b0, 1'b1, "lw100");
    xact(2, MSIZE4, 32'h100, 4'b1111, 32'h0,         32'h0,         1'b0, 1'b1, "sw100_zero");
    xact(2, MSIZE1, 32'h101, 4'b0010, 32'hABAB_ABAB, 32'h0000_AB00, 1'b0, 1'b1, "sb101");
    xact(2, MSIZE2, 32'h102, 4'b1100, 32'hCDEF_CDEF, 32'hCDEF_AB00, 1'b0, 1'b1, "sh102");
    xact(2, MSIZE1, 32'h102, 4'b0000, 32'h0,         32'hCDEF_AB00, 1'b0, 1'b1, "lb102");
    xact(2, MSIZE4, 32'h103, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b1, "lw103_misalign");
    xact(2, MSIZE4, 32'h100, 4'b0000, 32'h0,         32'hCDEF_AB00, 1'b0, 1'b1, "lw100_after_err");
    xact(2, MSIZE2, 32'h101, 4'b0110, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1, "sh101_misalign");
    xact(2, MSIZE1, 32'h100, 4'b0010, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1, "sb100_badlane");
    xact(2, MSIZE2, 32'h102, 4'b0011, 32'h1111_1111, 32'h0,         1'b1, 1'b1, "sh102_badhalf");
    xact(2, MSIZE4, 32'h100, 4'b0000, 32'h0,         32'hCDEF_AB00, 1'b0, 1'b1, "lw100_unchanged");
    xact(2, MSIZE4, 32'h300, 4'b1111, 32'h0,         32'h0,         1'b0, 1'b1, "sw300_zero");

    // Reset while waiting: response dropped, write kept.
    @(negedge clk);
    req_size = MSIZE4; req_addr = 32'h200; req_strobe = 4'b1111;
    req_data = 32'hFFFF_FFFF; req_valid = 1'b1;
    #1 chk("sw200 accept", 32'(o_addr_ok), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("sw200 wait no_ok", 32'(o_data_ok), 32'd0);
    reset = 1'b1;
    #1 chk("midwait rst data", o_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_data_ok) got = 1'b1;
    end
    chk("midwait no pulse", 32'(got), 32'd0);

    // Reset in the accept cycle: no write lands.
    @(negedge clk);
    reset = 1'b1;
    req_size = MSIZE4; req_addr = 32'h300; req_strobe = 4'b1111;
    req_data = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    xact(2, MSIZE4, 32'h200, 4'b0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, "lw200");
    xact(2, MSIZE4, 32'h300, 4'b0000, 32'h0, 32'h0,         1'b0, 1'b1, "lw300");

    // Shallow array wraps on upper address bits.
    sel = 1;
    xact(2, MSIZE4, 32'h40, 4'b1111, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1'b0, "wrap sw40");
    xact(2, MSIZE4, 32'h0,  4'b0000, 32'h0,         32'h5A5A_5A5A, 1'b0, 1'b1, "wrap lw0");

    // Single-cycle latency with valid held: accept and response alternate.
    sel = 2;
    xact(1, MSIZE4, 32'h0, 4'b1111, 32'h1111_1111, 32'h1111_1111, 1'b0, 1'b0, "lat1 sw0");
    @(negedge clk);
    req_size = MSIZE4; req_addr = 32'h0; req_strobe = 4'b0000; req_data = '0;
    req_valid = 1'b1;
    na = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("lat1 addr_ok[%0d]", i), 32'(o_addr_ok), 32'((i % 2) == 0));
      chk($sformatf("lat1 data_ok[%0d]", i), 32'(o_data_ok), 32'((i % 2) == 1));
      if (o_addr_ok) na++;
      if (o_data_ok) begin
        nd++;
        chk($sformatf("lat1 data[%0d]", i), o_data, 32'h1111_1111);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("lat1 accepts", 32'(na), 32'd4);
    chk("lat1 responses", 32'(nd), 32'd4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-side memory responder: the slave end of the request/response data bus driven by the pipeline memory stage. Accepts one load/store request at a time (address, size, byte strobe, store data), applies byte-lane writes to an internal word array, and after a fixed latency returns the full aligned 32-bit word with a one-cycle `dresp_data_ok` pulse. Lane selection and sign extension stay in the requester. Used as the data memory in simulation and on-chip scratchpad builds.

## Interface
- `DEPTH_LOG2`, 12: log2 of word count; array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 2: cycles from acceptance to `dresp_data_ok`; legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dreq_valid`  in  1  request present.
- `dreq_addr`  in  32  byte address.
- `dreq_size`  in  msize_t  MSIZE1/MSIZE2/MSIZE4.
- `dreq_strobe`  in  4  byte-write enables; 4'b0000 = load.
- `dreq_data`  in  32  store data, already lane-replicated by requester.
- `dresp_addr_ok`  out  1  request accepted this cycle.
- `dresp_data_ok`  out  1  one-cycle response pulse.
- `dresp_data`  out  32  aligned word at `{addr[31:2],2'b00}`.
- `dresp_err`  out  1  coincident with `dresp_data_ok`; request was illegal.

## Operation
- FSM states IDLE, WAIT, RESP; reset → IDLE.
- IDLE: `dresp_addr_ok = dreq_valid` (combinational). On accept, latch word index `addr[DEPTH_LOG2+1:2]` (upper bits ignored: wrap-around), read old word, commit strobed bytes on the same edge, load counter with LATENCY-1; go WAIT, or RESP directly if LATENCY==1.
- Read data returned is the word after the write (store returns merged word; loads see all prior stores).
- WAIT: decrement counter; at 0 go RESP. `dresp_addr_ok`=0.
- RESP: `dresp_data_ok`=1, `dresp_data` = latched word, `dresp_err` = latched error; next state IDLE. No accept in RESP.
- Legality check at accept: MSIZE4 needs `addr[1:0]==0` and strobe ∈ {0000,1111}; MSIZE2 needs `addr[0]==0` and strobe ∈ {0000, 0011 if addr[1]=0, 1100 if addr[1]=1}; MSIZE1 strobe ∈ {0000, one-hot at addr[1:0]}. Illegal: no array write, `dresp_data` = 32'h0, `dresp_err`=1.
- `dreq_*` ignored outside IDLE; requester holds fields stable until `dresp_addr_ok`. Dropping `dreq_valid` before accept is legal and has no effect.
- Accepted requests always complete; no cancellation except reset.

## Timing
- Accept at edge T (valid & addr_ok high in cycle T) → `dresp_data_ok` high in cycle T+LATENCY, exactly one cycle.
- Throughput: one request per LATENCY+1 cycles; next accept earliest in cycle T+LATENCY+1.
- Reset values: `dresp_addr_ok`=0 (state IDLE, valid-gated), `dresp_data_ok`=0, `dresp_data`=0, `dresp_err`=0, counter 0.
- Reset mid-WAIT/RESP: response discarded, no pulse after release; write already committed at accept remains. Array contents are not reset.
- Reset asserted in the accept cycle: request not accepted, no write.

## Structure
- Shared package: FSM state enum `dbus_state_t`, `msize_t` (existing), strobe-legality function `dbus_strobe_legal(size, addr_lo, strobe)` so the memory stage's assertions reuse it.
- Sub-module `dbus_word_ram`: single-port 2^DEPTH_LOG2×32 array, byte-write enable, write-first read; no reset.
- Top holds FSM, latency counter, latched response registers.

## Test plan
- LATENCY=2: SW 0x1234_5678 to 0x100, then LW 0x100 → accept cycles T, T+3; data_ok at T+2 and T+5; second `dresp_data`=0x1234_5678, err=0.
- SB 0xAB replicated, addr 0x101, strobe 0010 over word 0 → `dresp_data`=0x0000_AB00; subsequent SH 0xCDEF at 0x102 strobe 1100 → 0xCDEF_AB00.
- LW at 0x103 (MSIZE4) → data_ok with err=1, data 0; following LW 0x100 shows unchanged word.
- Reset asserted in WAIT after SW 0xFFFF_FFFF to 0x200 → no data_ok after release; LW 0x200 returns 0xFFFF_FFFF.
- DEPTH_LOG2=4: SW 0x5A5A_5A5A to 0x40 then LW 0x0 → returns 0x5A5A_5A5A (wrap).
- LATENCY=1, valid held continuously with 4 loads → addr_ok every 2nd cycle, data_ok in cycles between, counts match 4/4.
